half_adder_pipe: RTL and testbench
==================================

Name: half_adder_pipe

Overview:
- Registered, parameterisable half-adder stage: WIDTH independent 1-bit half-adder lanes.
- Per lane: sum = a XOR b, carry = a AND b.
- Results are captured into an output register with a valid/ready handshake.
- Used as a leaf arithmetic stage in datapaths needing a single pipeline register between operand source and consumer.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b carry a new operand pair this cycle
- in_ready  output  1  stage can accept an operand pair this cycle
- a  input  WIDTH  operand A, lane i = bit i
- b  input  WIDTH  operand B, lane i = bit i
- out_valid  output  1  sum/carry hold a valid result
- out_ready  input  1  consumer accepts the result this cycle
- sum  output  WIDTH  registered a XOR b per lane
- carry  output  WIDTH  registered a AND b per lane

Behaviour:
- Lane function: sum[i] = a[i]^b[i], carry[i] = a[i]&b[i].
  - No interaction between lanes; carry is NOT propagated to lane i+1.
- Truth table per lane (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Reset:
  - rst_n low asynchronously forces out_valid=0, sum=0, carry=0 immediately, regardless of clk.
  - Release is sampled on the next rising clk edge.
- in_ready is combinational: in_ready = !out_valid || out_ready.
  - During reset, in_ready = 1.
- Accept: when in_valid && in_ready at a rising edge:
  - sum/carry load the lane results of that cycle's a/b.
  - out_valid becomes 1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready && !in_valid at an edge -> out_valid becomes 0.
  - sum/carry hold their last values; they are don't-care but must not change.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new result loads and out_valid stays 1.
  - Full throughput is one result per cycle.
- Backpressure (out_valid && !out_ready):
  - in_ready=0.
  - sum/carry/out_valid hold stable until out_ready.
  - Inputs presented meanwhile are not accepted and not lost by the stage; the producer must hold them.
- a/b are ignored whenever in_valid=0 or in_ready=0.
- Reset asserted mid-transfer discards any held result; no partial output.
- No X propagation: outputs are defined at all times after reset.

Decomposition:
- Shared package: none required.
  - Optionally a localparam HA_MAX_WIDTH=64 in the team arithmetic package for the WIDTH range check.
- Sub-module: half_adder_lane, purely combinational 1-bit (a,b -> sum,carry), instantiated WIDTH times via generate.
- The top level holds the handshake and output register.
- Elaboration-time assertion that 1 <= WIDTH <= 64.

Test Plan:
- WIDTH=1, out_ready=1: apply a,b = 00,01,10,11 on consecutive cycles with in_valid=1.
  - Required: sum,carry one cycle later = 0,0 / 1,0 / 1,0 / 0,1, with out_valid continuously 1.
- WIDTH=8: a=8'hF0, b=8'hCC, accept.
  - Required next cycle: sum=8'h3C, carry=8'hC0; lane 7 carry is not propagated.
- Backpressure: accept a=1,b=1, hold out_ready=0 for 3 cycles while presenting a=0,b=1.
  - Required: carry=1, sum=0, out_valid=1 stable and in_ready=0 throughout.
  - After out_ready=1: next result sum=1, carry=0.
- Reset mid-operation: with out_valid=1, sum=1, pulse rst_n low between clock edges.
  - Required: out_valid, sum and carry go to 0 immediately (asynchronously) and in_ready=1.
- Idle drain: accept one pair, then in_valid=0, out_ready=1.
  - Required: out_valid 1 for exactly one cycle, then 0; sum/carry unchanged.

Source files
------------

// File: rtl/half_adder_pipe_pkg.sv
// Shared definitions for the registered half-adder stage: width limits and
// the handshake action decoded each cycle by the top level.
package half_adder_pipe_pkg;

   localparam int HA_MIN_WIDTH = 1;
   localparam int HA_MAX_WIDTH = 64;

   // What the output register does on the next rising edge.
   typedef enum logic [1:0] {
      HS_IDLE  = 2'd0,  // empty and nothing offered
      HS_LOAD  = 2'd1,  // capture a new operand pair (with or without a drain)
      HS_HOLD  = 2'd2,  // result held under backpressure
      HS_DRAIN = 2'd3   // result consumed, nothing new offered
   } hs_action_e;

   function automatic bit ha_width_ok(input int width);
      return (width >= HA_MIN_WIDTH) && (width <= HA_MAX_WIDTH);
   endfunction

endpackage

// File: rtl/half_adder_lane.sv
// One combinational half-adder lane: sum = a ^ b, carry = a & b.
module half_adder_lane (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule

// File: rtl/half_adder_pipe.sv
// WIDTH independent half-adder lanes followed by a single valid/ready output
// register. Carries never cross lanes.
module half_adder_pipe
   import half_adder_pipe_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);

   if (!ha_width_ok(WIDTH)) begin : g_width_chk
      $error("half_adder_pipe: WIDTH %0d outside %0d..%0d", WIDTH, HA_MIN_WIDTH, HA_MAX_WIDTH);
   end

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;
   logic             w_accept;
   hs_action_e       w_action;

   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_carry;
   logic             r_out_valid;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      half_adder_lane u_lane (
         .i_a     (a[gi]),
         .i_b     (b[gi]),
         .o_sum   (w_sum[gi]),
         .o_carry (w_carry[gi])
      );
   end

   // The register frees up in the same cycle the consumer takes the result,
   // which is what allows one result per cycle.
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_action = HS_IDLE;
      if (w_accept) begin
         w_action = HS_LOAD;
      end else if (r_out_valid && out_ready) begin
         w_action = HS_DRAIN;
      end else if (r_out_valid) begin
         w_action = HS_HOLD;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values. The data registers are reset as well as the
   // valid flag, because sum/carry are observable and must never be X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_carry     <= '0;
      end else begin
         case (w_action)
            HS_LOAD: begin
               r_sum       <= w_sum;
               r_carry     <= w_carry;
               r_out_valid <= 1'b1;
            end
            HS_DRAIN: r_out_valid <= 1'b0;
            default:  ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign carry     = r_carry;

endmodule

// File: tb/tb_half_adder_pipe.sv
// Scoreboard bench for half_adder_pipe: a 1-lane and an 8-lane instance share
// clock and reset; monitors pop hand-computed results on each output transfer.
module tb_half_adder_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       in_valid1, in_ready1, out_valid1, out_ready1;
   logic [0:0] a1, b1, sum1, carry1;

   logic       in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0] a8, b8, sum8, carry8;

   half_adder_pipe #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .carry(carry1)
   );

   half_adder_pipe #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .carry(carry8)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected results as {sum, carry}.
   logic [1:0]  sb1[$];
   logic [15:0] sb8[$];

   always @(negedge clk) begin
      if (rst_n && out_valid1 && out_ready1) begin
         if (sb1.size() == 0) begin
            check("sb1_unexpected_output", 1, 0);
         end else begin
            logic [1:0] e1;
            e1 = sb1.pop_front();
            check("w1_sum", sum1, e1[1]);
            check("w1_carry", carry1, e1[0]);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid8 && out_ready8) begin
         if (sb8.size() == 0) begin
            check("sb8_unexpected_output", 1, 0);
         end else begin
            logic [15:0] e8;
            e8 = sb8.pop_front();
            check("w8_sum", sum8, e8[15:8]);
            check("w8_carry", carry8, e8[7:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {a, b} and {sum, carry} per lane for the 1-lane truth table.
   logic [1:0]  tt_ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic [1:0]  tt_exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
   // {a, b, sum, carry} for the 8-lane stream, all hand-computed.
   logic [31:0] vec8   [6] = '{32'hF0CC_3CC0, 32'hFF01_FE01, 32'hAA55_FF00,
                               32'hFFFF_00FF, 32'h0000_0000, 32'h8181_0081};

   initial begin
      rst_n = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;

      // Reset state
      #3;
      check("rst_out_valid8", out_valid8, 0);
      check("rst_sum8", sum8, 0);
      check("rst_carry8", carry8, 0);
      check("rst_in_ready8", in_ready8, 1);
      check("rst_out_valid1", out_valid1, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // WIDTH=1 truth table, back-to-back
      for (int i = 0; i < 4; i++) begin
         a1 = tt_ab[i][1];
         b1 = tt_ab[i][0];
         in_valid1 = 1'b1;
         sb1.push_back(tt_exp[i]);
         tick();
         check("w1_out_valid_stream", out_valid1, 1);
      end
      in_valid1 = 1'b0;
      tick();
      check("w1_drain_out_valid", out_valid1, 0);
      check("w1_drain_sum_hold", sum1, 0);
      check("w1_drain_carry_hold", carry1, 1);

      // WIDTH=8 stream, lanes independent (F0/CC -> 3C/C0)
      for (int i = 0; i < 6; i++) begin
         a8 = vec8[i][31:24];
         b8 = vec8[i][23:16];
         in_valid8 = 1'b1;
         sb8.push_back(vec8[i][15:0]);
         tick();
         check("w8_out_valid_stream", out_valid8, 1);
      end
      in_valid8 = 1'b0;
      tick();
      check("w8_drain_out_valid", out_valid8, 0);

      // Backpressure: a=1,b=1 held while a=0,b=1 waits at the input
      out_ready8 = 1'b0;
      a8 = 8'h01; b8 = 8'h01; in_valid8 = 1'b1;
      sb8.push_back({8'h00, 8'h01});
      tick();
      a8 = 8'h00; b8 = 8'h01;
      sb8.push_back({8'h01, 8'h00});
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", in_ready8, 0);
         check("bp_out_valid", out_valid8, 1);
         check("bp_sum_hold", sum8, 8'h00);
         check("bp_carry_hold", carry8, 8'h01);
         tick();
      end
      out_ready8 = 1'b1;
      #1;
      check("bp_release_in_ready", in_ready8, 1);
      tick();
      in_valid8 = 1'b0;
      check("bp_next_sum", sum8, 8'h01);
      check("bp_next_carry", carry8, 8'h00);
      tick();
      check("bp_final_drain", out_valid8, 0);

      // Asynchronous reset mid-operation discards the held result
      out_ready8 = 1'b0;
      a8 = 8'h01; b8 = 8'h00; in_valid8 = 1'b1;
      sb8.push_back({8'h01, 8'h00});
      tick();
      in_valid8 = 1'b0;
      check("mid_pre_out_valid", out_valid8, 1);
      check("mid_pre_sum", sum8, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid8, 0);
      check("mid_rst_sum", sum8, 0);
      check("mid_rst_carry", carry8, 0);
      check("mid_rst_in_ready", in_ready8, 1);
      sb8.delete();
      tick();
      rst_n = 1'b1;
      out_ready8 = 1'b1;
      tick();
      check("post_rst_out_valid", out_valid8, 0);

      // Idle drain: one pair, then out_valid for exactly one cycle
      a8 = 8'h3C; b8 = 8'h0F; in_valid8 = 1'b1;
      sb8.push_back({8'h33, 8'h0C});
      tick();
      in_valid8 = 1'b0;
      check("idle_out_valid_one", out_valid8, 1);
      a8 = 8'hFF; b8 = 8'hFF;
      tick();
      check("idle_out_valid_zero", out_valid8, 0);
      check("idle_sum_hold", sum8, 8'h33);
      check("idle_carry_hold", carry8, 8'h0C);
      tick();
      check("idle_ignore_sum", sum8, 8'h33);
      check("idle_ignore_valid", out_valid8, 0);

      tick();
      check("sb1_drained", sb1.size(), 0);
      check("sb8_drained", sb8.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
